// File: rtl/ham74_pkg.sv
// Shared Hamming(7,4) definitions: FSM state type, codeword bit positions and
// the nibble encoder used by both the byte encoder and the downstream decoder.
package ham74_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_e;

  // Codeword position k (1..7) lives on bit k-1
  localparam int POS_P1 = 0;
  localparam int POS_P2 = 1;
  localparam int POS_D0 = 2;
  localparam int POS_P4 = 3;
  localparam int POS_D1 = 4;
  localparam int POS_D2 = 5;
  localparam int POS_D3 = 6;

  function automatic logic [6:0] ham74_encode(input logic [3:0] d);
    logic [6:0] cw;
    cw         = '0;
    cw[POS_D0] = d[0];
    cw[POS_D1] = d[1];
    cw[POS_D2] = d[2];
    cw[POS_D3] = d[3];
    cw[POS_P1] = d[0] ^ d[1] ^ d[3];
    cw[POS_P2] = d[0] ^ d[2] ^ d[3];
    cw[POS_P4] = d[1] ^ d[2] ^ d[3];
    return cw;
  endfunction

endpackage

// File: rtl/ham74_byte_encoder_if.sv
// Byte-in / codeword-out stream pair of the Hamming(7,4) byte encoder.
// master = producer/consumer side, slave = the encoder itself.
interface ham74_byte_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ham74_enc.sv
// Combinational Hamming(7,4) nibble encoder, a thin wrapper around the package function.
module ham74_enc
  import ham74_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] cw
);
  assign cw = ham74_encode(nibble);
endmodule

// File: rtl/ham74_byte_encoder.sv
// Hamming(7,4) byte encoder: accepts a byte, emits two registered 7-bit codewords,
// with optional single-bit error injection and a wrapping transfer counter.
module ham74_byte_encoder
  import ham74_pkg::*;
#(
  parameter int LSB_FIRST = 1,
  parameter int ERR_INJ   = 0,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ham74_byte_encoder_if.slave  bus,
  input  logic                 inj_en,
  input  logic [2:0]           inj_pos,
  output logic [CNT_W-1:0]     cw_count
);

  state_e     state;
  logic [7:0] byte_p0;
  logic [6:0] cw_p0;
  logic [3:0] nib_first;
  logic [3:0] nib_second;
  logic [3:0] enc_nib;
  logic [6:0] enc_cw;
  logic [6:0] inj_mask;
  logic       accept;
  logic       load;
  logic       xfer;

  // in_ready depends combinationally on out_ready so SECOND can chain into the next byte
  assign bus.in_ready  = (state == EMPTY) || ((state == SECOND) && bus.out_ready);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = cw_p0;

  always_comb begin
    nib_first  = (LSB_FIRST != 0) ? bus.in_data[3:0] : bus.in_data[7:4];
    nib_second = (LSB_FIRST != 0) ? byte_p0[7:4]     : byte_p0[3:0];
    enc_nib    = (state == FIRST) ? nib_second : nib_first;
    accept     = bus.in_valid && bus.in_ready;
    load       = accept || ((state == FIRST) && bus.out_ready);
    xfer       = (state != EMPTY) && bus.out_ready;
    inj_mask   = '0;
    if ((ERR_INJ != 0) && inj_en && (inj_pos != 3'd7)) begin
      inj_mask = 7'd1 << inj_pos;
    end
  end

  ham74_enc u_enc (
    .nibble (enc_nib),
    .cw     (enc_cw)
  );

  // Stage p0: held byte, output codeword, FSM state and transfer counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      byte_p0  <= '0;
      cw_p0    <= '0;
      cw_count <= '0;
    end else begin
      if (xfer) begin
        cw_count <= cw_count + 1'b1;
      end
      if (accept) begin
        byte_p0 <= bus.in_data;
      end
      if (load) begin
        cw_p0 <= enc_cw ^ inj_mask;
      end
      case (state)
        EMPTY:   if (bus.in_valid) state <= FIRST;
        FIRST:   if (bus.out_ready) state <= SECOND;
        SECOND:  if (bus.out_ready) state <= bus.in_valid ? FIRST : EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_ham74_byte_encoder.sv
// Directed bench for ham74_byte_encoder: a vector table for the streaming cases,
// plus hand-written sequences for mid-byte reset, counter wrap and injection/decoding.
module tb_ham74_byte_encoder;

  logic       clk;
  logic       rst_n;
  logic       inj_en;
  logic [2:0] inj_pos;
  logic [3:0] cw_count;
  int         checks;
  int         errors;

  ham74_byte_encoder_if bus ();

  ham74_byte_encoder #(
    .LSB_FIRST (1),
    .ERR_INJ   (1),
    .CNT_W     (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .inj_en   (inj_en),
    .inj_pos  (inj_pos),
    .cw_count (cw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       ie;
    logic [2:0] ip;
    logic       eov;
    logic [6:0] eod;
    logic       eir;
    logic [3:0] ecnt;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic ordy,
                              input logic ie, input logic [2:0] ip, input logic eov,
                              input logic [6:0] eod, input logic eir, input logic [3:0] ecnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.ie = ie; v.ip = ip;
    v.eov = eov; v.eod = eod; v.eir = eir; v.ecnt = ecnt;
    return v;
  endfunction

  function automatic logic [2:0] syndrome(input logic [6:0] c);
    return {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
  endfunction

  function automatic logic [6:0] correct(input logic [6:0] c);
    logic [6:0] r;
    logic [2:0] s;
    r = c;
    s = syndrome(c);
    if (s != 3'd0) r[s - 3'd1] = ~r[s - 3'd1];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Streaming table: inputs applied, outputs compared just before the next edge
    vecs[0]  = mk(1'b1, 8'hA1, 1'b1, 1'b0, 3'd7, 1'b0, 7'h00, 1'b1, 4'd0);
    vecs[1]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd7, 1'b1, 7'h07, 1'b0, 4'd0);
    vecs[2]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd7, 1'b1, 7'h52, 1'b1, 4'd1);
    vecs[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 3'd7, 1'b0, 7'h00, 1'b1, 4'd2);
    vecs[4]  = mk(1'b1, 8'h00, 1'b1, 1'b0, 3'd7, 1'b0, 7'h00, 1'b1, 4'd2);
    vecs[5]  = mk(1'b1, 8'hFF, 1'b1, 1'b0, 3'd7, 1'b1, 7'h00, 1'b0, 4'd2);
    vecs[6]  = mk(1'b1, 8'hFF, 1'b1, 1'b0, 3'd7, 1'b1, 7'h00, 1'b1, 4'd3);
    vecs[7]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd7, 1'b1, 7'h7F, 1'b0, 4'd4);
    vecs[8]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd7, 1'b1, 7'h7F, 1'b1, 4'd5);
    vecs[9]  = mk(1'b1, 8'hA1, 1'b0, 1'b0, 3'd7, 1'b0, 7'h00, 1'b1, 4'd6);
    for (int i = 10; i < 15; i++)
      vecs[i] = mk(1'b0, 8'h00, 1'b0, 1'b0, 3'd7, 1'b1, 7'h07, 1'b0, 4'd6);
    vecs[15] = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd7, 1'b1, 7'h07, 1'b0, 4'd6);
    vecs[16] = mk(1'b0, 8'h00, 1'b0, 1'b0, 3'd7, 1'b1, 7'h52, 1'b0, 4'd7);
    vecs[17] = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd7, 1'b1, 7'h52, 1'b1, 4'd7);
    vecs[18] = mk(1'b1, 8'hA1, 1'b1, 1'b1, 3'd4, 1'b0, 7'h00, 1'b1, 4'd8);
    vecs[19] = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd7, 1'b1, 7'h17, 1'b0, 4'd8);
    vecs[20] = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd7, 1'b1, 7'h52, 1'b1, 4'd9);
    vecs[21] = mk(1'b1, 8'hA1, 1'b1, 1'b1, 3'd7, 1'b0, 7'h00, 1'b1, 4'd10);
    vecs[22] = mk(1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b1, 7'h07, 1'b0, 4'd10);
    vecs[23] = mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd6, 1'b1, 7'h53, 1'b0, 4'd11);
    vecs[24] = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd7, 1'b1, 7'h53, 1'b1, 4'd11);

    rst_n   = 1'b0;
    inj_en  = 1'b0;
    inj_pos = 3'd7;
    drive(1'b0, 8'h00, 1'b0);
    #1;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_data", 32'(bus.out_data), 32'd0);
    chk("reset cw_count", 32'(cw_count), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy);
      inj_en  = vecs[i].ie;
      inj_pos = vecs[i].ip;
      #1;
      chk($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].eov));
      chk($sformatf("row%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].eir));
      chk($sformatf("row%0d cw_count", i), 32'(cw_count), 32'(vecs[i].ecnt));
      if (vecs[i].eov)
        chk($sformatf("row%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].eod));
      if (i == 1)
        chk("row1 syndrome", 32'(syndrome(bus.out_data)), 32'd0);
      tick();
    end
    inj_en  = 1'b0;
    inj_pos = 3'd7;

    // Reset asserted while the second codeword is pending
    drive(1'b1, 8'hA1, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    #1;
    chk("pre-reset out_data SECOND", 32'(bus.out_data), 32'h52);
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset cw_count", 32'(cw_count), 32'd0);
    chk("midreset out_data", 32'(bus.out_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post-reset no partial", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 8'hFF, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    #1;
    chk("post-reset cw1", 32'(bus.out_data), 32'h7F);
    tick();
    chk("post-reset cw2", 32'(bus.out_data), 32'h7F);
    chk("post-reset cw2 valid", 32'(bus.out_valid), 32'd1);
    tick();
    chk("post-reset count", 32'(cw_count), 32'd2);

    // 18 transfers on a 4-bit counter
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int b = 0; b < 9; b++) begin
      drive(1'b1, 8'(b * 29 + 3), 1'b1);
      #1;
      chk($sformatf("wrap byte%0d in_ready", b), 32'(bus.in_ready), 32'd1);
      tick();
      drive(1'b0, 8'h00, 1'b1);
      #1;
      chk($sformatf("wrap byte%0d out_valid", b), 32'(bus.out_valid), 32'd1);
      tick();
    end
    tick();
    chk("wrap cw_count", 32'(cw_count), 32'd2);
    chk("wrap idle", 32'(bus.out_valid), 32'd0);

    // Injected error is seen and repaired by a reference decoder
    drive(1'b1, 8'hA1, 1'b1);
    inj_en  = 1'b1;
    inj_pos = 3'd4;
    tick();
    drive(1'b0, 8'h00, 1'b1);
    inj_en  = 1'b0;
    inj_pos = 3'd7;
    #1;
    chk("inj cw", 32'(bus.out_data), 32'h17);
    chk("inj syndrome", 32'(syndrome(bus.out_data)), 32'd5);
    chk("inj corrected", 32'(correct(bus.out_data)), 32'h07);
    tick();
    chk("inj second cw", 32'(bus.out_data), 32'h52);
    chk("inj second syndrome", 32'(syndrome(bus.out_data)), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
